// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared coordinate width, standard timing sets and the registered raster record.
package video_timing_pkg;
  localparam int COORD_W = 11;
  localparam int MAX_TOT = 2 ** COORD_W;
  localparam int T720_H_ACTIVE = 1280;
  localparam int T720_H_FP     = 110;
  localparam int T720_H_SYNC   = 40;
  localparam int T720_H_BP     = 220;
  localparam int T720_V_ACTIVE = 720;
  localparam int T720_V_FP     = 5;
  localparam int T720_V_SYNC   = 5;
  localparam int T720_V_BP     = 20;
  localparam int T480_H_ACTIVE = 640;
  localparam int T480_H_FP     = 16;
  localparam int T480_H_SYNC   = 96;
  localparam int T480_H_BP     = 48;
  localparam int T480_V_ACTIVE = 480;
  localparam int T480_V_FP     = 10;
  localparam int T480_V_SYNC   = 2;
  localparam int T480_V_BP     = 33;
  typedef struct packed {
    logic               de;
    logic               hs;
    logic               vs;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } timing_t;
  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/timing_axis_cnt.sv
// timing_axis_cnt: one raster axis counter with active-region and sync-window decode.
module timing_axis_cnt
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = T720_H_ACTIVE,
  parameter int FP     = T720_H_FP,
  parameter int SYNC   = T720_H_SYNC,
  parameter int BP     = T720_H_BP,
  parameter int POL    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap,
  output logic               active,
  output logic               sync
);
  localparam int   TOT     = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int   SYNC_S  = ACTIVE + FP;
  localparam int   SYNC_E  = ACTIVE + FP + SYNC;
  localparam logic SYNC_ON = 1'(POL);
  if (TOT > MAX_TOT) begin : g_tot_chk
    $error("timing_axis_cnt: axis total %0d exceeds %0d", TOT, MAX_TOT);
  end
  logic [COORD_W-1:0] cnt_q, cnt_d;
  always_comb begin
    wrap   = inc && (int'(cnt_q) == TOT - 1);
    cnt_d  = wrap ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
    active = int'(cnt_q) < ACTIVE;
    sync   = (int'(cnt_q) >= SYNC_S && int'(cnt_q) < SYNC_E) ? SYNC_ON : !SYNC_ON;
  end
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: free-running raster timing with registered DE/sync/coordinates and
// line/frame start pulses that fire once per decoded position, never while en holds.
module hdmi_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = T720_H_ACTIVE,
  parameter int H_FP     = T720_H_FP,
  parameter int H_SYNC   = T720_H_SYNC,
  parameter int H_BP     = T720_H_BP,
  parameter int V_ACTIVE = T720_V_ACTIVE,
  parameter int V_FP     = T720_V_FP,
  parameter int V_SYNC   = T720_V_SYNC,
  parameter int V_BP     = T720_V_BP,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic               DE,
  output logic               hdmi_h_sync,
  output logic               hdmi_v_sync,
  output logic [COORD_W-1:0] x_pixel,
  output logic [COORD_W-1:0] y_pixel,
  output logic               line_start,
  output logic               frame_start
);
  localparam timing_t TIM_RST = '{de: 1'b0, hs: !1'(HS_POL), vs: !1'(VS_POL), x: '0, y: '0};
  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_wrap, h_act, v_act, h_sync, v_sync;
  timing_t            tim_d, tim_q;
  logic               ls_d, ls_q, fs_d, fs_q;
  timing_axis_cnt #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)) u_h (
    .clk(clk), .reset(reset), .inc(en),
    .cnt(h_cnt), .wrap(h_wrap), .active(h_act), .sync(h_sync)
  );
  timing_axis_cnt #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)) u_v (
    .clk(clk), .reset(reset), .inc(en & h_wrap),
    .cnt(v_cnt), .wrap(), .active(v_act), .sync(v_sync)
  );
  always_comb begin
    tim_d.de = h_act && v_act;
    tim_d.hs = h_sync;
    tim_d.vs = v_sync;
    tim_d.x  = tim_d.de ? h_cnt : '0;
    tim_d.y  = tim_d.de ? v_cnt : '0;
    ls_d     = tim_d.de && h_cnt == '0;
    fs_d     = ls_d && v_cnt == '0;
  end
  // pulses are gated by en so a frozen raster cannot repeat them
  always_ff @(posedge clk) begin
    if (reset) begin
      tim_q <= TIM_RST;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      if (en) tim_q <= tim_d;
      ls_q <= en && ls_d;
      fs_q <= en && fs_d;
    end
  end
  assign DE          = tim_q.de;
  assign hdmi_h_sync = tim_q.hs;
  assign hdmi_v_sync = tim_q.vs;
  assign x_pixel     = tim_q.x;
  assign y_pixel     = tim_q.y;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_hdmi_timing_gen.sv
// tb_hdmi_timing_gen: scoreboarded check of 720p, a tiny custom raster and 640x480 (active-low syncs).
module tb_hdmi_timing_gen;
  typedef struct packed {
    logic de, hs, vs;
    logic [10:0] x, y;
    logic ls, fs;
  } obs_t;
  typedef struct {int ha, hf, hs, hb, va, vf, vs, vb; bit hp, vp;} tp_t;
  typedef struct {int k; obs_t exp;} vec_t;

  logic clk = 1'b0, reset = 1'b1, en = 1'b0;
  logic de [3], hs [3], vs [3], ls [3], fs [3];
  logic [10:0] x [3], y [3];
  always #5 clk = ~clk;

  hdmi_timing_gen u0 (
    .clk(clk), .reset(reset), .en(en), .DE(de[0]), .hdmi_h_sync(hs[0]), .hdmi_v_sync(vs[0]),
    .x_pixel(x[0]), .y_pixel(y[0]), .line_start(ls[0]), .frame_start(fs[0])
  );
  hdmi_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                    .V_SYNC(2), .V_BP(1), .HS_POL(1), .VS_POL(0)) u1 (
    .clk(clk), .reset(reset), .en(en), .DE(de[1]), .hdmi_h_sync(hs[1]), .hdmi_v_sync(vs[1]),
    .x_pixel(x[1]), .y_pixel(y[1]), .line_start(ls[1]), .frame_start(fs[1])
  );
  hdmi_timing_gen #(.H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48), .V_ACTIVE(480), .V_FP(10),
                    .V_SYNC(2), .V_BP(33), .HS_POL(0), .VS_POL(0)) u2 (
    .clk(clk), .reset(reset), .en(en), .DE(de[2]), .hdmi_h_sync(hs[2]), .hdmi_v_sync(vs[2]),
    .x_pixel(x[2]), .y_pixel(y[2]), .line_start(ls[2]), .frame_start(fs[2])
  );

  int   n_cmp = 0, n_bad = 0;
  obs_t sb [3][$];
  tp_t  P [3];
  int   mh [3], mv [3];
  obs_t last [3];
  vec_t tbl [11];

  function automatic obs_t mk(logic d, logic h, logic v, int xx, int yy, logic l, logic f);
    return '{de: d, hs: h, vs: v, x: 11'(xx), y: 11'(yy), ls: l, fs: f};
  endfunction

  function automatic obs_t decode(int h, int v, tp_t p);
    obs_t o;
    o.de = h < p.ha && v < p.va;
    o.hs = (h >= p.ha + p.hf && h < p.ha + p.hf + p.hs) ? p.hp : !p.hp;
    o.vs = (v >= p.va + p.vf && v < p.va + p.vf + p.vs) ? p.vp : !p.vp;
    o.x  = o.de ? 11'(h) : 11'd0;
    o.y  = o.de ? 11'(v) : 11'd0;
    o.ls = o.de && h == 0;
    o.fs = o.ls && v == 0;
    return o;
  endfunction

  function automatic obs_t actual(int i);
    return '{de: de[i], hs: hs[i], vs: vs[i], x: x[i], y: y[i], ls: ls[i], fs: fs[i]};
  endfunction

  task automatic chk(string nm, int a, int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic chk_obs(string nm, obs_t a, obs_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got de=%b hs=%b vs=%b x=%0d y=%0d ls=%b fs=%b expected de=%b hs=%b vs=%b x=%0d y=%0d ls=%b fs=%b",
               nm, a.de, a.hs, a.vs, a.x, a.y, a.ls, a.fs, e.de, e.hs, e.vs, e.x, e.y, e.ls, e.fs);
    end
  endtask

  task automatic step(input bit r, input bit e);
    reset = r;
    en    = e;
    for (int i = 0; i < 3; i++) begin
      obs_t o;
      if (r) begin
        o     = mk(1'b0, !P[i].hp, !P[i].vp, 0, 0, 1'b0, 1'b0);
        mh[i] = 0;
        mv[i] = 0;
      end else if (e) begin
        o = decode(mh[i], mv[i], P[i]);
        mh[i]++;
        if (mh[i] == P[i].ha + P[i].hf + P[i].hs + P[i].hb) begin
          mh[i] = 0;
          mv[i]++;
          if (mv[i] == P[i].va + P[i].vf + P[i].vs + P[i].vb) mv[i] = 0;
        end
      end else begin
        o    = last[i];
        o.ls = 1'b0;
        o.fs = 1'b0;
      end
      last[i] = o;
      sb[i].push_back(o);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (sb[i].size() == 0) chk($sformatf("sb%0d_empty", i), 0, 1);
      else chk_obs($sformatf("sb%0d", i), actual(i), sb[i].pop_front());
    end
  endtask

  initial begin
    int j = 0, hs0_n = 0, hs0_first = 0, de0_last = 0, ls0_k2 = 0;
    int hs2_n = 0, ls2_k2 = 0, ls1_n = 0, vs1_n = 0;
    int fs1_k [$];
    P[0] = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};
    P[1] = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b0};
    P[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    tbl[0]  = '{1,    mk(1, 0, 0, 0, 0, 1, 1)};
    tbl[1]  = '{2,    mk(1, 0, 0, 1, 0, 0, 0)};
    tbl[2]  = '{1280, mk(1, 0, 0, 1279, 0, 0, 0)};
    tbl[3]  = '{1281, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{1390, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{1391, mk(0, 1, 0, 0, 0, 0, 0)};
    tbl[6]  = '{1430, mk(0, 1, 0, 0, 0, 0, 0)};
    tbl[7]  = '{1431, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{1650, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{1651, mk(1, 0, 0, 0, 1, 1, 0)};
    tbl[10] = '{1652, mk(1, 0, 0, 1, 1, 0, 0)};

    repeat (3) step(1'b1, 1'b0);
    chk("rst_de0", int'(de[0]), 0);
    chk("rst_hs0", int'(hs[0]), 0);
    chk("rst_hs2", int'(hs[2]), 1);
    chk("rst_vs1", int'(vs[1]), 1);

    for (int k = 1; k <= 1700; k++) begin
      step(1'b0, 1'b1);
      if (j < 11 && tbl[j].k == k) begin
        chk_obs($sformatf("tbl_k%0d", k), actual(0), tbl[j].exp);
        j++;
      end
      if (k <= 1650) begin
        hs0_n += int'(hs[0]);
        if (hs[0] && hs0_first == 0) hs0_first = k;
        if (de[0]) de0_last = k;
      end
      if (ls[0] && k > 1 && ls0_k2 == 0) ls0_k2 = k;
      if (k <= 800) hs2_n += int'(!hs[2]);
      if (ls[2] && k > 1 && ls2_k2 == 0) ls2_k2 = k;
      if (fs[1]) fs1_k.push_back(k);
      if (k <= 120) begin
        ls1_n += int'(ls[1]);
        vs1_n += int'(!vs[1]);
      end
    end
    chk("hs0_width", hs0_n, 40);
    chk("hs0_gap", hs0_first - de0_last, 111);
    chk("ls0_period", ls0_k2 - 1, 1650);
    chk("hs2_low_width", hs2_n, 96);
    chk("ls2_period", ls2_k2 - 1, 800);
    chk("fs1_count", fs1_k.size(), 15);
    if (fs1_k.size() >= 15) begin
      chk("fs1_period", fs1_k[1] - fs1_k[0], 120);
      chk("fs1_last", fs1_k[14], 1681);
    end
    chk("ls1_per_frame", ls1_n, 4);
    chk("vs1_low_clks", vs1_n, 30);

    repeat (3000) step(1'b0, 1'($urandom_range(0, 1)));

    step(1'b1, 1'b0);
    repeat (700) step(1'b0, 1'b1);
    chk("pre_rst_x0", int'(x[0]), 699);
    step(1'b1, 1'b1);
    chk("midrst_de0", int'(de[0]), 0);
    chk("midrst_x0", int'(x[0]), 0);
    chk("midrst_hs0", int'(hs[0]), 0);
    chk("midrst_hs2", int'(hs[2]), 1);
    step(1'b0, 1'b1);
    chk("restart_de0", int'(de[0]), 1);
    chk("restart_fs0", int'(fs[0]), 1);
    chk("restart_ls0", int'(ls[0]), 1);
    chk("restart_y0", int'(y[0]), 0);
    repeat (20) step(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
